// File: rtl/rv_ifetch.sv
// Instruction fetch stage: credit-limited in-order word requests, a pending-PC queue matching
// responses to addresses, and an instruction FIFO with a registered output stage.
module rv_ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] pend_q, pend_d, drop_q, drop_d, stor_cnt_q, stor_cnt_d;
  logic [AW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [AW-1:0] st_wr_q, st_wr_d, st_rd_q, st_rd_d;
  logic [31:0]   pq_mem_q  [FIFO_DEPTH];
  logic [31:0]   st_pc_q   [FIFO_DEPTH];
  logic [31:0]   st_data_q [FIFO_DEPTH];
  logic          inst_valid_q, inst_valid_d;
  logic [31:0]   inst_q, inst_d, inst_pc_q, inst_pc_d;

  logic          req_fire, rsp_fire, rsp_keep, out_pop, out_free, stor_pop, bypass, stor_push;
  logic [31:0]   credits_used, rsp_pc;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credits cover both in-flight requests and every buffered instruction, output stage included.
  assign out_pop        = inst_valid_q && inst_ready;
  assign credits_used   = 32'(pend_q) + 32'(stor_cnt_q) + 32'(inst_valid_q) - 32'(out_pop);
  assign imem_req_valid = !rst && !redirect_valid && (credits_used < FIFO_DEPTH);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_pc    = pq_mem_q[pq_rd_q];
  assign rsp_fire  = imem_rsp_valid && (pend_q != '0);
  assign rsp_keep  = rsp_fire && (drop_q == '0) && !redirect_valid;
  assign out_free  = !inst_valid_q || inst_ready;
  assign stor_pop  = !redirect_valid && out_free && (stor_cnt_q != '0);
  assign bypass    = out_free && (stor_cnt_q == '0) && rsp_keep;
  assign stor_push = rsp_keep && !bypass;

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  always_comb begin
    pc_d    = pc_q;
    pend_d  = pend_q + CW'(req_fire) - CW'(rsp_fire);
    drop_d  = drop_q;
    pq_wr_d = pq_wr_q + AW'(req_fire);
    pq_rd_d = pq_rd_q + AW'(rsp_fire);
    if (req_fire) pc_d = pc_q + 32'd4;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      drop_d = pend_q - CW'(rsp_fire);
    end else if (rsp_fire && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_comb begin
    st_wr_d      = st_wr_q + AW'(stor_push);
    st_rd_d      = st_rd_q + AW'(stor_pop);
    stor_cnt_d   = stor_cnt_q + CW'(stor_push) - CW'(stor_pop);
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    if (redirect_valid) begin
      st_wr_d      = '0;
      st_rd_d      = '0;
      stor_cnt_d   = '0;
      inst_valid_d = 1'b0;
    end else if (stor_pop) begin
      inst_valid_d = 1'b1;
      inst_d       = st_data_q[st_rd_q];
      inst_pc_d    = st_pc_q[st_rd_q];
    end else if (bypass) begin
      inst_valid_d = 1'b1;
      inst_d       = imem_rsp_data;
      inst_pc_d    = rsp_pc;
    end else if (out_free) begin
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_q       <= '0;
      drop_q       <= '0;
      stor_cnt_q   <= '0;
      pq_wr_q      <= '0;
      pq_rd_q      <= '0;
      st_wr_q      <= '0;
      st_rd_q      <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      drop_q       <= drop_d;
      stor_cnt_q   <= stor_cnt_d;
      pq_wr_q      <= pq_wr_d;
      pq_rd_q      <= pq_rd_d;
      st_wr_q      <= st_wr_d;
      st_rd_q      <= st_rd_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pq_mem_q[pq_wr_q] <= pc_q;
    if (stor_push) begin
      st_pc_q[st_wr_q]   <= rsp_pc;
      st_data_q[st_wr_q] <= imem_rsp_data;
    end
  end

  a_rsp_has_pending : assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (pend_q != '0));
  a_no_fifo_overflow : assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> ((32'(stor_cnt_q) + 32'(inst_valid_q)) < FIFO_DEPTH));

endmodule

// File: tb/tb_rv_ifetch.sv
// Directed bench for rv_ifetch: a latency-configurable memory model drives the main instance,
// a second instance with a wrapping RESET_PC covers pc wrap and mid-stream reset.
module tb_rv_ifetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid;
  logic        inst_valid, inst_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, inst, inst_pc;

  logic        w_rst, w_req_valid, w_req_ready, w_rsp_valid, w_redirect, w_iv, w_irdy;
  logic [31:0] w_req_addr, w_rsp_data, w_redirect_pc, w_inst, w_pc;

  rv_ifetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  rv_ifetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(w_req_ready), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .redirect_valid(w_redirect),
    .redirect_pc(w_redirect_pc), .inst_valid(w_iv), .inst(w_inst),
    .inst_pc(w_pc), .inst_ready(w_irdy)
  );

  typedef struct {logic [31:0] addr; int due;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} dl_t;
  typedef struct {logic rv; logic [31:0] addr; logic iv; logic [31:0] pc;} vec_t;

  mreq_t       memq[$];
  dl_t         dlog[$];
  logic [31:0] rlog[$];
  int          cyc, lat, n_chk, n_pass;
  logic        s_rv, s_iv, ws_rv, ws_iv, w_pv;
  logic [31:0] s_addr, s_pc, s_inst, ws_addr, ws_pc, ws_inst, w_pa;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // One clock cycle: present due responses, sample just before the edge, log handshakes.
  task automatic tick();
    mreq_t m;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    w_rsp_valid = w_pv;
    w_rsp_data  = mdata(w_pa);
    #1;
    s_rv = imem_req_valid; s_addr = imem_req_addr;
    s_iv = inst_valid;     s_pc   = inst_pc;       s_inst = inst;
    ws_rv = w_req_valid;   ws_addr = w_req_addr;
    ws_iv = w_iv;          ws_pc   = w_pc;         ws_inst = w_inst;
    if (imem_rsp_valid) void'(memq.pop_front());
    if (s_rv && imem_req_ready) begin
      rlog.push_back(s_addr);
      m.addr = s_addr;
      m.due  = cyc + lat;
      memq.push_back(m);
    end
    if (s_iv && inst_ready) begin
      dl_t d;
      d.pc = s_pc;
      d.data = s_inst;
      dlog.push_back(d);
    end
    if (rst) memq.delete();
    w_pv = ws_rv && w_req_ready;
    w_pa = ws_addr;
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_hold();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic release_rst();
    rst = 1'b0; cyc = 0;
    memq.delete(); rlog.delete(); dlog.delete();
  endtask

  task automatic chk_dlog(input string name, input int k, input logic [31:0] exp_pc);
    chk({name, "_pc"}, (dlog.size() > k) ? dlog[k].pc : 32'hxxxx_xxxx, exp_pc);
    chk({name, "_data"}, (dlog.size() > k) ? dlog[k].data : 32'hxxxx_xxxx, mdata(exp_pc));
  endtask

  vec_t vt[6];
  int   bad, stale;

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; lat = 1;
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    w_rst = 1'b1; w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = '0;
    w_redirect = 1'b0; w_redirect_pc = '0; w_irdy = 1'b1; w_pv = 1'b0; w_pa = '0;
    @(negedge clk);

    // Reset state, then the fill/stream sequence from the table
    reset_hold();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h100);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    vt[0] = '{1'b1, 32'h100, 1'b0, 32'h0};
    vt[1] = '{1'b1, 32'h104, 1'b0, 32'h0};
    vt[2] = '{1'b1, 32'h108, 1'b1, 32'h100};
    vt[3] = '{1'b1, 32'h10C, 1'b1, 32'h104};
    vt[4] = '{1'b1, 32'h110, 1'b1, 32'h108};
    vt[5] = '{1'b1, 32'h114, 1'b1, 32'h10C};
    release_rst();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("fill_req_valid[%0d]", i), s_rv, vt[i].rv);
      chk($sformatf("fill_req_addr[%0d]", i), s_addr, vt[i].addr);
      chk($sformatf("fill_inst_valid[%0d]", i), s_iv, vt[i].iv);
      if (vt[i].iv) begin
        chk($sformatf("fill_inst_pc[%0d]", i), s_pc, vt[i].pc);
        chk($sformatf("fill_inst[%0d]", i), s_inst, mdata(vt[i].pc));
      end
    end

    // Decoder stall: credits cap issue at four, output held, then in-order drain
    reset_hold(); release_rst();
    inst_ready = 1'b0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 2 && (s_iv !== 1'b1 || s_pc !== 32'h100 || s_inst !== mdata(32'h100))) bad++;
    end
    chk("stall_req_count", rlog.size(), 4);
    chk("stall_req_valid_low", s_rv, 0);
    chk("stall_hold_bad_cycles", bad, 0);
    rlog.delete(); dlog.delete(); inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("stall_resume_addr", (rlog.size() > 0) ? rlog[0] : 32'hxxxx_xxxx, 32'h110);
    for (int k = 0; k < 5; k++) chk_dlog($sformatf("stall_drain[%0d]", k), k, 32'h100 + 4 * k);

    // Redirect with two responses in flight on a 3-cycle memory
    lat = 3; reset_hold(); release_rst();
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h2002;
    tick();
    chk("redir_req_blocked", s_rv, 0);
    redirect_valid = 1'b0; redirect_pc = '0; dlog.delete(); stale = 0;
    tick();
    chk("redir_next_valid", s_rv, 1);
    chk("redir_next_addr", s_addr, 32'h2000);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_iv && s_pc[31:12] != 20'h00002) stale++;
    end
    chk("redir_stale_cycles", stale, 0);
    for (int k = 0; k < 3; k++) chk_dlog($sformatf("redir_deliv[%0d]", k), k, 32'h2000 + 4 * k);
    lat = 1;

    // Redirect coinciding with a response and an output handshake
    reset_hold(); release_rst();
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    tick();
    chk("same_cyc_req_blocked", s_rv, 0);
    redirect_valid = 1'b0; redirect_pc = '0;
    tick();
    chk("same_cyc_flushed", s_iv, 0);
    chk("same_cyc_req_valid", s_rv, 1);
    chk("same_cyc_req_addr", s_addr, 32'h3000);
    tick();
    chk("same_cyc_empty_2", s_iv, 0);
    tick();
    chk("same_cyc_restart_valid", s_iv, 1);
    chk("same_cyc_restart_pc", s_pc, 32'h3000);
    chk("same_cyc_restart_inst", s_inst, mdata(32'h3000));

    // Memory not ready for five cycles at 0x40
    reset_hold(); release_rst();
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40; imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_valid[%0d]", i), s_rv, 1);
      chk($sformatf("hold_addr[%0d]", i), s_addr, 32'h40);
    end
    imem_req_ready = 1'b1;
    tick();
    chk("hold_hs_addr", s_addr, 32'h40);
    tick();
    chk("hold_next_addr", s_addr, 32'h44);
    tick();
    chk("hold_deliv_valid", s_iv, 1);
    chk("hold_deliv_pc", s_pc, 32'h40);

    // PC wrap and mid-stream reset on the second instance
    rst = 1'b1; w_rst = 1'b0;
    tick();
    chk("wrap_req_valid0", ws_rv, 1);
    chk("wrap_req_addr0", ws_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_req_addr1", ws_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_req_addr2", ws_addr, 32'h0000_0000);
    chk("wrap_inst_pc0", ws_pc, 32'hFFFF_FFF8);
    tick();
    chk("wrap_inst_pc1", ws_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_inst_valid2", ws_iv, 1);
    chk("wrap_inst_pc2", ws_pc, 32'h0000_0000);
    chk("wrap_inst2", ws_inst, mdata(32'h0000_0000));
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    tick();
    chk("midrst_inst_valid", ws_iv, 0);
    chk("midrst_req_valid", ws_rv, 1);
    chk("midrst_req_addr", ws_addr, 32'hFFFF_FFF8);
    tick(); tick();
    chk("midrst_refetch_valid", ws_iv, 1);
    chk("midrst_refetch_pc", ws_pc, 32'hFFFF_FFF8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
